// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the decode stage and the HI/LO multiply/divide sequencer.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             mt_wr;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_data;
  logic             rd_req;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, src_a, src_b, mt_wr, mt_sel, mt_data, rd_req, flush,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, src_a, src_b, mt_wr, mt_sel, mt_data, rd_req, flush,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle HI/LO sequencer: fixed-latency multiply, radix-2 restoring divide,
// MTHI/MTLO writes, pipeline stall on HI/LO collisions and abort on flush.
module hilo_muldiv_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [2:0] {IDLE, MUL, DIV_PRE, DIV_ITER, DIV_POST} state_t;

  localparam int             CW       = $clog2(WIDTH + MUL_CYCLES + 1);
  localparam logic [CW-1:0]  MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, rem, quo, hi_r, lo_r;
  logic [CW-1:0]    cnt;
  logic             sgn_r, q_neg, r_neg, done_r, commit;

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u, prod;
  logic        [WIDTH:0]     rem_sh, trial;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  // Full-width products; sign extension to 2*WIDTH keeps the truncated product exact.
  assign prod_s = $signed({{WIDTH{a_r[WIDTH-1]}}, a_r}) * $signed({{WIDTH{b_r[WIDTH-1]}}, b_r});
  assign prod_u = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
  assign prod   = sgn_r ? prod_s : prod_u;

  // One restoring step: trial[WIDTH] set means the partial remainder was smaller than the divisor.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, b_r};

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE:     if (bus.start && !bus.flush) state_nxt = bus.op[1] ? DIV_PRE : MUL;
      MUL:      if (cnt == MUL_LAST) begin
                  state_nxt = IDLE;
                  commit    = 1'b1;
                end
      DIV_PRE:  state_nxt = DIV_ITER;
      DIV_ITER: if (cnt == DIV_LAST) state_nxt = DIV_POST;
      DIV_POST: begin
                  state_nxt = IDLE;
                  commit    = 1'b1;
                end
      default:  state_nxt = IDLE;
    endcase
    if (state != IDLE && bus.flush) begin
      state_nxt = IDLE;
      commit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sgn_r  <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= commit;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            a_r   <= bus.src_a;
            b_r   <= bus.src_b;
            sgn_r <= bus.op[0];
            cnt   <= '0;
          end
          if (bus.mt_wr && !bus.flush) begin
            if (bus.mt_sel) hi_r <= bus.mt_data;
            else            lo_r <= bus.mt_data;
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (commit) {hi_r, lo_r} <= prod;
        end
        DIV_PRE: begin
          // b_r is replaced by the divisor magnitude; zero stays zero for the divide-by-zero check.
          b_r   <= magnitude(b_r, sgn_r);
          quo   <= magnitude(a_r, sgn_r);
          rem   <= '0;
          q_neg <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          r_neg <= sgn_r & a_r[WIDTH-1];
          cnt   <= '0;
        end
        DIV_ITER: begin
          cnt <= cnt + 1'b1;
          rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end
        DIV_POST: begin
          if (commit) begin
            if (b_r == '0) begin
              lo_r <= '1;
              hi_r <= a_r;
            end else begin
              lo_r <= apply_sign(quo, q_neg);
              hi_r <= apply_sign(rem, r_neg);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;
  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.busy && (bus.start || bus.rd_req || bus.mt_wr);
  assign bus.done  = done_r;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq: directed and random mul/div against an arithmetic model.
module tb_hilo_muldiv_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv_seq #(.WIDTH(32), .MUL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the MIPS HI/LO result rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] pu;
    longint      sa, sb, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        pu = {32'b0, a} * {32'b0, b};
        {eh, el} = pu;
      end
      2'b01: begin
        q = sa * sb;
        {eh, el} = q;
      end
      default: begin
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else if (o == 2'b10) begin
          el = a / b;
          eh = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          el = 32'(q);
          eh = 32'(r);
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit rd, input string tag);
    logic [31:0] eh, el;
    int lat, busy_cyc, stall_bad, exp_lat;
    model(o, a, b, eh, el);
    exp_lat   = o[1] ? 34 : 2;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start  = 1'b0;
    bus.src_a  = $urandom;
    bus.src_b  = $urandom;
    bus.rd_req = rd;
    lat = 0; busy_cyc = 0; stall_bad = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cyc++;
      if (bus.stall !== rd) stall_bad++;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {eh, el});
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    if (rd) begin
      chk({tag, "_stall_during"}, 64'(stall_bad), 64'd0);
      chk({tag, "_stall_after"}, 64'(bus.stall), 64'd0);
    end
    bus.rd_req = 1'b0;
    tick();
    chk({tag, "_done_pulse_width"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0;
    bus.mt_wr = 0; bus.mt_sel = 0; bus.mt_data = 0; bus.rd_req = 0; bus.flush = 0;

    repeat (2) tick();
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_ctrl", {61'd0, bus.busy, bus.stall, bus.done}, 64'd0);
    rst = 1'b1;
    tick();

    run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 0, "mult_neg2x3");
    run_op(2'b10, 32'd100, 32'd7, 1, "divu_100_7");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    run_op(2'b11, 32'h1234_5678, 32'd0, 0, "div_by_zero");
    run_op(2'b10, 32'h8765_4321, 32'd0, 0, "divu_by_zero");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 3 == 2) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 2 == 1) ra = -ra;
      run_op(ro, ra, rb, i[0], $sformatf("rand%0d", i));
    end

    // MTHI / MTLO preload
    bus.mt_wr = 1; bus.mt_sel = 1; bus.mt_data = 32'hAAAA_0000;
    tick();
    bus.mt_sel = 0; bus.mt_data = 32'h0000_5555;
    tick();
    bus.mt_wr = 0;
    chk("mthi_mtlo", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h0000_5555});

    // DIVU with blocked mt_wr, then flushed at edge 10
    bus.start = 1; bus.op = 2'b10; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    tick();
    bus.start = 0;
    bus.mt_wr = 1; bus.mt_sel = 1; bus.mt_data = 32'h5555_5555;
    #1;
    chk("mt_wr_busy_stall", 64'(bus.stall), 64'd1);
    repeat (3) tick();
    bus.mt_wr = 0;
    repeat (6) tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_hilo_kept", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h0000_5555});
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_hilo_final", {bus.hi, bus.lo}, {32'hAAAA_0000, 32'h0000_5555});

    // Reset during DIV at edge 20
    bus.start = 1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    tick();
    bus.start = 0;
    repeat (19) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    chk("midrst_no_done", 64'(done_cnt), 64'd0);

    // start with flush in the same cycle is dropped
    bus.start = 1; bus.flush = 1; bus.op = 2'b00; bus.src_a = 32'd5; bus.src_b = 32'd7;
    tick();
    bus.start = 0; bus.flush = 0;
    chk("start_flush_busy", 64'(bus.busy), 64'd0);
    repeat (3) tick();
    chk("start_flush_hilo", {bus.hi, bus.lo}, 64'd0);

    run_op(2'b01, 32'h0000_0005, 32'hFFFF_FFF9, 0, "mult_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource, driven by the decode-stage `start`, ALU2Op, RHLWr/RHLSel_Wr and RHL_visit controls.
- Captures operands, runs an iterative multiply (fixed latency) or a radix-2 restoring divide, then commits HI/LO.
- Stalls the pipeline when a later HI/LO access collides with an operation in flight.
- Aborts cleanly on an exception flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 2, cycles from the accepting edge to HI/LO commit for MULT/MULTU (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  issue a mul/div (the decode `start` signal).
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV (the ALU2Op encoding).
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- mt_wr  in  1  MTHI/MTLO write request.
- mt_sel  in  1  1 = HI, 0 = LO.
- mt_data  in  WIDTH  MTHI/MTLO data.
- rd_req  in  1  MFHI/MFLO read in progress.
- flush  in  1  exception/eret flush; cancels the pending operation.
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.
- busy  out  1  operation in flight (state != IDLE).
- stall  out  1  hold the issuing pipeline stage.
- done  out  1  one-cycle pulse, coincident with the HI/LO commit becoming visible.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; hi=0, lo=0, busy=0, stall=0, done=0; counter and operand registers cleared.
- States:
  - IDLE: waiting for a request.
  - MUL: count MUL_CYCLES.
  - DIV_PRE: 1 cycle; take magnitudes for DIV and record the quotient and remainder signs.
  - DIV_ITER: exactly WIDTH cycles, one quotient bit per cycle, MSB first.
  - DIV_POST: 1 cycle; apply signs.
- IDLE transitions:
  - start && !flush: latch src_a, src_b, op. Go to MUL if op[1]==0, else DIV_PRE.
  - start && flush in the same cycle: start is ignored; stay IDLE.
- MUL:
  - Product is the 2*WIDTH-bit signed product for MULT, unsigned for MULTU, of the latched operands.
  - {hi,lo} is written on the MUL_CYCLES-th edge after the accepting edge; same edge returns to IDLE and sets done=1 for one cycle.
- DIV:
  - Commit occurs on edge WIDTH+2 after the accepting edge (34 for WIDTH=32).
  - lo = quotient, hi = remainder.
  - DIV: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0.
- Divide by zero: runs the full latency; lo=all ones, hi=src_a, no sign correction, for both DIV and DIVU.
- Latched operands are used throughout; src_a/src_b changes after acceptance have no effect.
- busy = (state != IDLE), combinational from the state register.
- stall = busy && (start || rd_req || mt_wr), combinational. In the cycle after commit busy==0, so a waiting MFHI/MFLO reads the new value.
- mt_wr:
  - Accepted only when IDLE and !flush; writes hi or lo per mt_sel on that edge.
  - While busy, mt_wr is ignored (the stall holds it for retry).
- flush while busy: next edge returns to IDLE; hi/lo unchanged; no done pulse; any partial result is discarded.
- rst asserted mid-operation overrides everything, including a commit due on the same edge.
- done is registered; it is never asserted in the same cycle as an mt_wr write.

Test Plan:
- Reset then MULT src_a=0xFFFFFFFE (-2), src_b=0x00000003 -> after 2 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once, busy high exactly 2 cycles.
- DIVU src_a=100, src_b=7 -> commit on edge 34: lo=14, hi=2. rd_req asserted during busy -> stall=1 until busy drops.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIV by zero src_a=0x12345678 -> lo=0xFFFFFFFF, hi=0x12345678 after 34 edges.
- Preload hi=0xAAAA0000 via MTHI, start DIVU, assert flush at edge 10 -> state IDLE next cycle, hi=0xAAAA0000 unchanged, no done. mt_wr during busy -> stall=1, no write.
- Assert rst=0 mid-DIV at edge 20 -> hi=lo=0, busy=0. start && flush in the same IDLE cycle -> no operation started.
